fix_field_assembler: RTL

- Sits directly downstream of the FIX byte tokenizer, which emits per-byte tag/value strobes.
- Converts the ASCII tag digits of each field to a binary tag number and packs the value bytes into a fixed-width record.
- Pushes each completed field into a small FWFT FIFO, exposed to the message decoder through a valid/ready handshake.
- The input stream has no backpressure, so the FIFO absorbs bursts; records that do not fit are dropped and counted.

---
 rtl/fix_field_assembler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fix_field_assembler.sv
// fix_field_assembler
//   Assembles FIX fields from the tokenizer's per-byte tag/value strobes.
//   It converts the ASCII tag digits to a binary tag number and packs the
//   value bytes into a fixed-width record. Completed records are queued in a
//   first-word-fall-through FIFO. The input side has no backpressure, so a
//   record that arrives while the FIFO is full (and nothing is popped in the
//   same cycle) is dropped and counted.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   data_i          tokenizer byte, meaningful only while a strobe is high
//   tag_s_i         data_i is a tag digit
//   value_s_i       data_i is a value byte (wins when both strobes are high)
//   field_valid_o   record available at FIFO head
//   field_ready_i   consumer accepts the head record
//   field_tag_o     binary tag number
//   field_len_o     stored value byte count
//   field_value_o   value bytes, byte k at [8k+7:8k], unused bytes zero
//   field_err_o     tag/length/sequence error seen in this field
//   field_last_o    tag == 10 (checksum field, last of message)
//   overflow_o      one-cycle pulse after a record is dropped
//   drop_cnt_o      saturating count of dropped records
//   dbg_state       current assembler state (IDLE=0, TAG=1, SEP=2, VALUE=3)
//
// Handshake: the head record is transferred on every rising clk edge where
//   field_valid_o and field_ready_i are both high. While field_valid_o is high
//   and field_ready_i is low, all head outputs hold their values. field_valid_o
//   never depends on field_ready_i.
module fix_field_assembler #(
   parameter int TAG_W   = 16,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           data_i,
   input  logic                 tag_s_i,
   input  logic                 value_s_i,
   output logic                 field_valid_o,
   input  logic                 field_ready_i,
   output logic [TAG_W-1:0]     field_tag_o,
   output logic [LEN_W-1:0]     field_len_o,
   output logic [8*MAX_LEN-1:0] field_value_o,
   output logic                 field_err_o,
   output logic                 field_last_o,
   output logic                 overflow_o,
   output logic [7:0]           drop_cnt_o,
   output logic [1:0]           dbg_state
);

   localparam int VAL_W = 8 * MAX_LEN;
   localparam int REC_W = TAG_W + LEN_W + VAL_W + 2;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [TAG_W+3:0] TAG_LIMIT = {4'b0000, {TAG_W{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TAG   = 2'd1,
      S_SEP   = 2'd2,
      S_VALUE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Field accumulators
   logic [TAG_W-1:0] tag_q, tag_d, tag_b;
   logic [LEN_W-1:0] len_q, len_d, len_b;
   logic [VAL_W-1:0] val_q, val_d, val_b;
   logic             err_q, err_d, err_b;

   // Strobe decode: both strobes high counts as a value byte plus an error
   logic is_val, is_tag, is_both, is_digit;
   assign is_val   = value_s_i;
   assign is_tag   = tag_s_i & ~value_s_i;
   assign is_both  = tag_s_i & value_s_i;
   assign is_digit = (data_i >= 8'h30) && (data_i <= 8'h39);

   logic do_commit, do_tag, do_store, set_err;

   // Next-state and action decode
   always_comb begin
      state_d   = state_q;
      do_commit = 1'b0;
      do_tag    = 1'b0;
      do_store  = 1'b0;
      set_err   = is_both;
      unique case (state_q)
         S_IDLE: begin
            if (is_val) begin
               // value with no tag: tag stays 0 and the field is flagged
               state_d  = S_VALUE;
               do_store = 1'b1;
               set_err  = 1'b1;
            end else if (is_tag) begin
               state_d = S_TAG;
               do_tag  = 1'b1;
            end
         end
         S_TAG: begin
            if (is_val) begin
               state_d  = S_VALUE;
               do_store = 1'b1;
            end else if (is_tag) begin
               do_tag = 1'b1;
            end else begin
               state_d = S_SEP;
            end
         end
         S_SEP: begin
            if (is_val) begin
               state_d  = S_VALUE;
               do_store = 1'b1;
            end else if (is_tag) begin
               // empty value: close this field and start the next tag
               state_d   = S_TAG;
               do_commit = 1'b1;
               do_tag    = 1'b1;
            end
         end
         S_VALUE: begin
            if (is_val) begin
               do_store = 1'b1;
            end else if (is_tag) begin
               state_d   = S_TAG;
               do_commit = 1'b1;
               do_tag    = 1'b1;
            end else begin
               state_d   = S_IDLE;
               do_commit = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A commit clears the accumulators in the same cycle, so the byte that
   // arrives with the commit is applied to an empty field.
   assign tag_b = do_commit ? '0 : tag_q;
   assign len_b = do_commit ? '0 : len_q;
   assign val_b = do_commit ? '0 : val_q;
   assign err_b = do_commit ? 1'b0 : err_q;

   // Four spare bits hold tag*10+9 without wrapping
   logic [TAG_W+3:0] tag_ext;
   assign tag_ext = ({4'b0000, tag_b} * (TAG_W+4)'(10)) + (TAG_W+4)'(data_i[3:0]);

   always_comb begin
      tag_d = tag_b;
      len_d = len_b;
      val_d = val_b;
      err_d = err_b | set_err;
      if (do_tag) begin
         if (!is_digit) begin
            err_d = 1'b1;
         end else if (tag_ext > TAG_LIMIT) begin
            tag_d = '1;
            err_d = 1'b1;
         end else begin
            tag_d = tag_ext[TAG_W-1:0];
         end
      end
      if (do_store) begin
         if (len_b < LEN_MAX) begin
            for (int k = 0; k < MAX_LEN; k++) begin
               if (len_b == LEN_W'(k)) val_d[8*k +: 8] = data_i;
            end
            len_d = len_b + LEN_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         len_q   <= '0;
         val_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         len_q   <= len_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   // Record FIFO; pointers carry one wrap bit to tell full from empty
   logic [REC_W-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             empty, full, pop, push, drop;
   logic [REC_W-1:0] rec_in, head;
   logic             overflow_q;
   logic [7:0]       drop_cnt_q;

   assign rec_in = {tag_q, len_q, val_q, err_q, (tag_q == TAG_W'(10))};
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop    = ~empty & field_ready_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push   = do_commit & (~full | pop);
   assign drop   = do_commit & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         overflow_q <= drop;
         if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   // Outputs are forced low during reset; head fields read zero when empty
   assign head          = mem[rd_ptr[AW-1:0]];
   assign field_valid_o = ~empty & ~rst;
   assign field_tag_o   = field_valid_o ? head[REC_W-1 -: TAG_W]         : '0;
   assign field_len_o   = field_valid_o ? head[REC_W-TAG_W-1 -: LEN_W]   : '0;
   assign field_value_o = field_valid_o ? head[VAL_W+1:2]                : '0;
   assign field_err_o   = field_valid_o & head[1];
   assign field_last_o  = field_valid_o & head[0];
   assign overflow_o    = overflow_q & ~rst;
   assign drop_cnt_o    = rst ? 8'd0 : drop_cnt_q;
   assign dbg_state     = rst ? 2'b00 : state_q;

endmodule
